// File: rtl/acq_pkg.sv
// acq_pkg: shared types and constants for the acquisition RAM writer.
// Holds the control and write FSM state encodings plus the flag bit positions
// within a sample word at the default 16-bit width.
package acq_pkg;

  localparam int BITS_DEFAULT = 16;
  localparam int INDEX_BIT    = BITS_DEFAULT - 1;  // index pulse seen with this word
  localparam int RDDATA_BIT   = BITS_DEFAULT - 2;  // read-data transition flag

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT_INDEX,
    C_ACQUIRE,
    C_DRAIN
  } ctl_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_STROBE
  } wr_state_e;

endpackage

// File: rtl/acq_sync_fifo.sv
// acq_sync_fifo: small synchronous FIFO with first-word-fall-through read data.
// Ports: push_i/push_dat_i write side, pop_i/pop_dat_o read side, full_o/empty_o
// status, flush_i empties the FIFO at the next edge (flush wins over push).
module acq_sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q;
  logic [DEPTH_LOG2:0] rd_ptr_q;
  logic                do_push;
  logic                do_pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign pop_dat_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge CLOCK) begin
    if (RESET || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2 + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/acq_ram_writer.sv
// acq_ram_writer: gates the disc reader (RUN), buffers its sample words in a FIFO
// and writes them to SRAM at sequential addresses with a setup + strobe cycle pair.
// Ports: START/ABORT/START_ON_INDEX/STOP_INDEX_COUNT control, IN_DATA/IN_WRITE from
// the reader, SRAM_ADDR/SRAM_DQ/SRAM_WE_N to SRAM, BUSY/DONE/RAM_FULL/OVERRUN/
// WORDS_WRITTEN status (all registered).
module acq_ram_writer
  import acq_pkg::*;
#(
  parameter int BITS            = BITS_DEFAULT,
  parameter int ADDR_BITS       = 19,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 START_ON_INDEX,
  input  logic [7:0]           STOP_INDEX_COUNT,
  input  logic [BITS-1:0]      IN_DATA,
  input  logic                 IN_WRITE,
  output logic                 RUN,
  output logic [ADDR_BITS-1:0] SRAM_ADDR,
  output logic [BITS-1:0]      SRAM_DQ,
  output logic                 SRAM_WE_N,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 RAM_FULL,
  output logic                 OVERRUN,
  output logic [ADDR_BITS:0]   WORDS_WRITTEN
);

  localparam int IDX = BITS - 1;  // INDEX flag position at this word width

  ctl_state_e           ctl_q;
  wr_state_e            wr_q;
  logic [7:0]           idx_cnt_q, idx_cnt_d;
  logic                 run_q, busy_q, we_n_q, done_q, full_q, ovr_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [BITS-1:0]      dq_q;
  logic [ADDR_BITS:0]   ww_q;

  logic            collecting, take, stop_hit, abort_hit, wr_last, drop;
  logic            fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [BITS-1:0] fifo_rd_dat;

  always_comb begin
    collecting = (ctl_q == C_WAIT_INDEX) || (ctl_q == C_ACQUIRE);
    // While waiting for the index, only an INDEX word is taken (it is the trigger).
    take       = IN_WRITE && ((ctl_q == C_ACQUIRE) ||
                              ((ctl_q == C_WAIT_INDEX) && IN_DATA[IDX]));
    idx_cnt_d  = (take && IN_DATA[IDX]) ? idx_cnt_q + 8'd1 : idx_cnt_q;
    stop_hit   = take && IN_DATA[IDX] && (STOP_INDEX_COUNT != 8'd0) &&
                 (idx_cnt_d == STOP_INDEX_COUNT);
    abort_hit  = ABORT && (ctl_q != C_IDLE);
    // Write to the top address is completing: the RAM is now full.
    wr_last    = (wr_q == W_STROBE) && (&addr_q);
    fifo_flush = abort_hit || wr_last;
    fifo_push  = take && !fifo_flush;
    // Pop whenever a new setup cycle can start: from idle or straight out of a strobe.
    fifo_pop   = !fifo_empty && !fifo_flush && (wr_q != W_SETUP);
    drop       = fifo_push && fifo_full && !fifo_pop;
  end

  acq_sync_fifo #(
    .WIDTH      (BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .flush_i    (fifo_flush),
    .push_i     (fifo_push),
    .push_dat_i (IN_DATA),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_rd_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ctl_q     <= C_IDLE;
      wr_q      <= W_IDLE;
      idx_cnt_q <= '0;
      run_q     <= 1'b0;
      busy_q    <= 1'b0;
      we_n_q    <= 1'b1;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      ovr_q     <= 1'b0;
      addr_q    <= '0;
      dq_q      <= '0;
      ww_q      <= '0;
    end else begin
      // RUN/BUSY follow the control state one cycle later.
      run_q     <= collecting;
      busy_q    <= (ctl_q != C_IDLE);
      idx_cnt_q <= idx_cnt_d;
      if (drop) ovr_q <= 1'b1;

      // Control FSM
      case (ctl_q)
        C_IDLE: begin
          if (START) begin
            addr_q    <= '0;
            ww_q      <= '0;
            idx_cnt_q <= '0;
            done_q    <= 1'b0;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ctl_q     <= START_ON_INDEX ? C_WAIT_INDEX : C_ACQUIRE;
          end
        end
        C_WAIT_INDEX, C_ACQUIRE: begin
          if (abort_hit) begin
            ctl_q <= C_DRAIN;
          end else if (stop_hit) begin
            ctl_q  <= C_DRAIN;
            done_q <= 1'b1;
          end else if (take) begin
            ctl_q <= C_ACQUIRE;
          end
        end
        C_DRAIN: begin
          if (!abort_hit && fifo_empty && (wr_q == W_IDLE)) ctl_q <= C_IDLE;
        end
        default: ctl_q <= C_IDLE;
      endcase

      // Write FSM: setup cycle (data/address valid, WE_N high), then strobe cycle.
      case (wr_q)
        W_IDLE: begin
          if (fifo_pop) begin
            dq_q <= fifo_rd_dat;
            wr_q <= W_SETUP;
          end
        end
        W_SETUP: begin
          we_n_q <= 1'b0;
          wr_q   <= W_STROBE;
        end
        W_STROBE: begin
          we_n_q <= 1'b1;
          ww_q   <= ww_q + (ADDR_BITS + 1)'(1);
          if (!(&addr_q)) addr_q <= addr_q + ADDR_BITS'(1);  // hold at top, never wrap
          if (fifo_pop) begin
            dq_q <= fifo_rd_dat;
            wr_q <= W_SETUP;
          end else begin
            wr_q <= W_IDLE;
          end
        end
        default: wr_q <= W_IDLE;
      endcase

      // RAM full overrides the control FSM; any buffered or arriving word is lost.
      if (wr_last) begin
        full_q <= 1'b1;
        ctl_q  <= C_IDLE;
        if (!abort_hit) begin
          done_q <= 1'b1;
          if (!fifo_empty || take) ovr_q <= 1'b1;
        end
      end
    end
  end

  assign RUN           = run_q;
  assign SRAM_ADDR     = addr_q;
  assign SRAM_DQ       = dq_q;
  assign SRAM_WE_N     = we_n_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign RAM_FULL      = full_q;
  assign OVERRUN       = ovr_q;
  assign WORDS_WRITTEN = ww_q;

endmodule
